// File: rtl/mul_seq_ctrl_pkg.sv
// Shared processor package: controller state encoding, datapath width defaults,
// and the multiplier timing constants used to size the settle window.
package mul_seq_ctrl_pkg;

    localparam logic [1:0] IDLE      = 2'b00;
    localparam logic [1:0] SETTLE    = 2'b01;
    localparam logic [1:0] WRITEBACK = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE      = IDLE,
        ST_SETTLE    = SETTLE,
        ST_WRITEBACK = WRITEBACK
    } mul_state_t;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    // Combinational multiplier propagation delay and system clock period, in the same time units.
    localparam int MUL_DELAY  = 3;
    localparam int CLK_PERIOD = 8;

    localparam int CNT_W = 4;

    // Smallest settle count whose window strictly exceeds the multiplier delay.
    function automatic int min_settle_cycles(input int period);
        return (MUL_DELAY / period) + 1;
    endfunction

endpackage

// File: rtl/mul_settle_counter.sv
// Loadable 4-bit down-counter timing the operand settle window.
// It stops at zero and flags zero combinationally.
module mul_settle_counter
    import mul_seq_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencing controller for the combinational 8-bit multiplier: captures operands,
// holds them for SETTLE_CYCLES, samples the product and issues a one-cycle register write.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int ADDR_W        = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] operand1,
    input  logic [DATA_W-1:0] operand2,
    input  logic [ADDR_W-1:0] dest_addr,
    output logic [DATA_W-1:0] mul_data1,
    output logic [DATA_W-1:0] mul_data2,
    input  logic [DATA_W-1:0] mul_result,
    output logic              stall,
    output logic              busy,
    output logic              write_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              done,
    output logic [1:0]        dbg_state,
    output logic [CNT_W-1:0]  dbg_count
);

    // SETTLE_CYCLES must lie in 1..15; the counter is loaded with S-1 so the
    // product is sampled on the S-th edge after the accept edge.
    localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(SETTLE_CYCLES - 1);

    mul_state_t        state;
    logic [ADDR_W-1:0] dest_q;
    logic              accept;
    logic              cnt_dec;
    logic              cnt_zero;

    // Handshake: start is a request sampled every rising edge; it is taken only when
    // the controller is IDLE or in WRITEBACK, and stall is the not-ready indication
    // back to the CPU, high while settling or while a request is being accepted.
    assign accept  = start && ((state == ST_IDLE) || (state == ST_WRITEBACK));
    assign cnt_dec = (state == ST_SETTLE) && !cnt_zero;
    assign stall   = reset_n && ((state == ST_SETTLE) || accept);

    mul_settle_counter u_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (accept),
        .load_value (LOAD_VALUE),
        .dec        (cnt_dec),
        .count      (dbg_count),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            mul_data1  <= '0;
            mul_data2  <= '0;
            dest_q     <= '0;
            write_en   <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            write_en <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE, ST_WRITEBACK: begin
                    if (start) begin
                        mul_data1 <= operand1;
                        mul_data2 <= operand2;
                        dest_q    <= dest_addr;
                        state     <= ST_SETTLE;
                        busy      <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    busy <= 1'b1;
                    if (cnt_zero) begin
                        // Low DATA_W product bits only; overflow is discarded.
                        write_data <= mul_result;
                        write_addr <= dest_q;
                        write_en   <= 1'b1;
                        done       <= 1'b1;
                        state      <= ST_WRITEBACK;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with S=2 and a behavioural 8-bit multiplier;
// register-file writes are checked against a queue of expected {addr, data}.
module tb_mul_seq_ctrl;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] operand1, operand2;
    logic [2:0] dest_addr;
    logic [7:0] mul_data1, mul_data2, mul_result;
    logic       stall, busy, write_en, done;
    logic [2:0] write_addr;
    logic [7:0] write_data;
    logic [1:0] dbg_state;
    logic [3:0] dbg_count;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int cyc       = 0;
    int writes_seen = 0;
    int wr_cyc[$];
    logic [10:0] exp_q[$];

    mul_seq_ctrl #(.SETTLE_CYCLES(S), .DATA_W(8), .ADDR_W(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .operand1   (operand1),
        .operand2   (operand2),
        .dest_addr  (dest_addr),
        .mul_data1  (mul_data1),
        .mul_data2  (mul_data2),
        .mul_result (mul_result),
        .stall      (stall),
        .busy       (busy),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .done       (done),
        .dbg_state  (dbg_state),
        .dbg_count  (dbg_count)
    );

    // Clock / reset-independent free-running pieces.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign mul_result = 8'(16'(mul_data1) * 16'(mul_data2));

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every write seen mid-cycle must match the oldest expectation.
    always @(negedge clk) begin
        if (write_en === 1'b1) begin
            writes_seen++;
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(write_en), 32'd0);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                check("write_addr", 32'(write_addr), 32'(e[10:8]));
                check("write_data", 32'(write_data), 32'(e[7:0]));
                check("done_with_write", 32'(done), 32'd1);
            end
        end
    end

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
        start     = 1'b1;
        operand1  = a;
        operand2  = b;
        dest_addr = d;
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        exp_q.push_back({d, p[7:0]});
    endtask

    // One complete operation from IDLE, checking latency and control outputs.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
        int k;
        drive(a, b, d);
        push_exp(a, b, d);
        #1;
        check("stall_on_request", 32'(stall), 32'd1);
        step();
        start = 1'b0;
        check("state_settle", 32'(dbg_state), 32'd1);
        check("captured_op1", 32'(mul_data1), 32'(a));
        check("captured_op2", 32'(mul_data2), 32'(b));
        k = 0;
        do begin
            step();
            k++;
        end while (write_en !== 1'b1 && k < 20);
        check("write_latency", 32'(k), 32'(S));
        check("stall_in_writeback", 32'(stall), 32'd0);
        step();
        check("write_en_one_cycle", 32'(write_en), 32'd0);
        check("back_to_idle", 32'(dbg_state), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int n0;
        int w0;
        reset_n = 1'b0; start = 1'b1;
        operand1 = '0; operand2 = '0; dest_addr = '0;
        #2;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_outputs", {mul_data1, mul_data2, write_data, 5'(write_en), 3'(write_addr)}, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        start = 1'b0;
        step(); step();
        reset_n = 1'b1;
        step();

        // Basic op: 5*7 -> 0x23 into reg 3, stall for three cycles.
        drive(8'd5, 8'd7, 3'd3);
        push_exp(8'd5, 8'd7, 3'd3);
        #1 check("t1_stall_c0", 32'(stall), 32'd1);
        step(); start = 1'b0;
        check("t1_stall_c1", 32'(stall), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_count", 32'(dbg_count), 32'(S - 1));
        step();
        check("t1_stall_c2", 32'(stall), 32'd1);
        check("t1_no_early_write", 32'(write_en), 32'd0);
        step();
        check("t1_write_en", 32'(write_en), 32'd1);
        check("t1_done", 32'(done), 32'd1);
        check("t1_stall_drop", 32'(stall), 32'd0);
        check("t1_state_wb", 32'(dbg_state), 32'd2);
        step();
        check("t1_done_pulse", 32'(done), 32'd0);

        // Overflow cases.
        do_op(8'h10, 8'h10, 3'd5);
        do_op(8'hFF, 8'hFF, 3'd7);

        // START during SETTLE is ignored.
        w0 = writes_seen;
        drive(8'h0B, 8'h03, 3'd4);
        push_exp(8'h0B, 8'h03, 3'd4);
        step();
        drive(8'd9, 8'd9, 3'd6);
        step();
        start = 1'b0;
        check("t3_op1_held", 32'(mul_data1), 32'h0B);
        step();
        check("t3_write", 32'(write_en), 32'd1);
        step(); step(); step();
        check("t3_one_write", 32'(writes_seen - w0), 32'd1);
        check("t3_idle", 32'(busy), 32'd0);

        // Back-to-back with START held high.
        n0 = wr_cyc.size();
        drive(8'd3, 8'd4, 3'd1);
        push_exp(8'd3, 8'd4, 3'd1);
        push_exp(8'd6, 8'd6, 3'd2);
        step();
        drive(8'd6, 8'd6, 3'd2);
        step();
        check("t4_op2_held", 32'(mul_data2), 32'd4);
        step();
        check("t4_wb_stall", 32'(stall), 32'd1);
        step();
        start = 1'b0;
        check("t4_no_idle", 32'(dbg_state), 32'd1);
        check("t4_second_op", 32'(mul_data1), 32'd6);
        step(); step(); step(); step();
        if (wr_cyc.size() >= n0 + 2)
            check("t4_spacing", 32'(wr_cyc[n0 + 1] - wr_cyc[n0]), 32'(S + 1));
        else
            check("t4_two_writes", 32'(wr_cyc.size() - n0), 32'd2);

        // Asynchronous reset in the second SETTLE cycle drops the operation.
        w0 = writes_seen;
        drive(8'h0A, 8'h02, 3'd6);
        step(); start = 1'b0;
        step();
        #2 reset_n = 1'b0;
        #1;
        check("t5_async_state", 32'(dbg_state), 32'd0);
        check("t5_async_outputs", {mul_data1, mul_data2, write_data, 5'(write_en), 3'(write_addr)}, 32'd0);
        check("t5_async_flags", {29'd0, stall, busy, done}, 32'd0);
        check("t5_count", 32'(dbg_count), 32'd0);
        step();
        reset_n = 1'b1;
        step(); step();
        check("t5_dropped", 32'(writes_seen - w0), 32'd0);
        do_op(8'h0C, 8'h0D, 3'd6);

        // Operands changing every cycle during SETTLE.
        drive(8'h11, 8'h0E, 3'd0);
        push_exp(8'h11, 8'h0E, 3'd0);
        step();
        for (int i = 0; i < S; i++) begin
            start    = 1'b0;
            operand1 = 8'($urandom_range(0, 255));
            operand2 = 8'($urandom_range(0, 255));
            #1;
            check("t6_op1_stable", 32'(mul_data1), 32'h11);
            check("t6_op2_stable", 32'(mul_data2), 32'h0E);
            step();
        end
        check("t6_write", 32'(write_en), 32'd1);
        step(); step();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("total_writes", 32'(writes_seen), 32'd8);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequencing controller that sits directly upstream of the 8-bit combinational multiplier in the processor datapath. It captures a multiply operation's operands and destination register on a start request, holds them stable on the multiplier inputs for a fixed number of settle cycles, then samples the product. It also stalls the CPU while the product settles, and issues a one-cycle register-file write of the low 8 product bits.

## Interface
- SETTLE_CYCLES, 2: cycles the operands are held before the product is sampled; legal range 1..15, and 0 is illegal.
- DATA_W, 8: operand and result width.
- ADDR_W, 3: register-file address width.

- CLK  in  1  single clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  request a multiply; sampled on the rising edge.
- OPERAND1  in  DATA_W  first operand, valid with START.
- OPERAND2  in  DATA_W  second operand, valid with START.
- DEST_ADDR  in  ADDR_W  destination register, valid with START.
- MUL_DATA1  out  DATA_W  registered operand driven to the multiplier.
- MUL_DATA2  out  DATA_W  registered operand driven to the multiplier.
- MUL_RESULT  in  DATA_W  product returned by the multiplier.
- STALL  out  1  hold the PC and instruction register.
- BUSY  out  1  high whenever the state is not IDLE.
- WRITE_EN  out  1  register-file write enable.
- WRITE_ADDR  out  ADDR_W  register-file write address.
- WRITE_DATA  out  DATA_W  register-file write data.
- DONE  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, SETTLE, WRITEBACK.
- IDLE:
  - START=1 at an edge → load MUL_DATA1/2 from OPERAND1/2 and latch DEST_ADDR.
  - Load the counter with SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE:
  - Counter ≠ 0 at an edge → decrement.
  - Counter = 0 at an edge → register MUL_RESULT into WRITE_DATA, drive WRITE_ADDR from the latched destination, go to WRITEBACK.
  - START is ignored in SETTLE; no queueing.
- WRITEBACK (exactly one cycle):
  - WRITE_EN=1 and DONE=1.
  - START=1 at the closing edge → accept a new operation exactly as from IDLE (back-to-back).
  - START=0 at the closing edge → go to IDLE.
- MUL_DATA1/2 change only on accept; they stay stable through SETTLE and WRITEBACK.
- STALL is combinational: (state==SETTLE) | (START & state∈{IDLE,WRITEBACK}).
- Arithmetic: WRITE_DATA is the low DATA_W bits of the product; overflow is silently discarded and there is no flag.
- Reset (asserted at any time, including mid-SETTLE):
  - State → IDLE, counter → 0.
  - Every output → 0: MUL_DATA1/2, WRITE_*, DONE, BUSY.
  - STALL is 0 while RESET_N=0.
  - The in-flight operation is dropped with no write.
- First rising edge after RESET_N deasserts behaves as IDLE.

## Timing
- Accept edge E0 (START=1 in IDLE) → SETTLE occupies cycles E0..E0+S-1, where S=SETTLE_CYCLES.
- WRITE_DATA is sampled at edge E0+S.
- WRITEBACK is the cycle after E0+S; the register file commits at edge E0+S+1.
- Total latency from accept edge to write commit: S+1 edges.
- Throughput: one operation per S+1 cycles when back-to-back.
- Multiplier settle budget: S × clock period must exceed the multiplier propagation delay (3 units). The default S=2 gives margin at the 8-unit system clock.
- STALL drops in the WRITEBACK cycle, so the instruction after the multiply fetches one cycle early and overlaps the write.

## Structure
- Shared processor package holds:
  - state encoding localparams: IDLE=2'b00, SETTLE=2'b01, WRITEBACK=2'b10;
  - DATA_W and ADDR_W defaults;
  - the multiplier delay constant used to size SETTLE_CYCLES.
- One sub-module: mul_settle_counter, a 4-bit loadable down-counter with load, decrement and zero flag, asynchronously reset by RESET_N.
- The multiplier itself is instantiated by the parent datapath, not inside this block.

## Test plan
All scenarios use S=2 with the 8-bit multiplier connected.

- Reset then START with 5, 7, DEST 3 → STALL high for 3 cycles; WRITE_EN and DONE high exactly one cycle, 3 edges after accept; WRITE_DATA=0x23, WRITE_ADDR=3.
- 0x10 × 0x10 → WRITE_DATA=0x00; 0xFF × 0xFF → WRITE_DATA=0x01. No flags and no extra cycles.
- START pulsed again with 9, 9 during SETTLE → ignored; the first result writes normally; exactly one WRITE_EN pulse.
- Back-to-back: START held high with 3×4 (DEST 1) then 6×6 (DEST 2) → writes 0x0C to reg 1, then 0x24 to reg 2, exactly 3 cycles apart; no IDLE cycle between them.
- RESET_N low in the second SETTLE cycle → all outputs 0 immediately (asynchronously); no WRITE_EN; the next START completes correctly.
- Change OPERAND1/2 every cycle during SETTLE → MUL_DATA1/2 remain at the captured values and the result matches the captured operands.
